// File: rtl/i2c_ccd_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared I2C controller.
interface i2c_ccd_arbiter_if #(
   parameter int unsigned N_REQ = 2
);
   logic [N_REQ-1:0]    iREQ;
   logic [24*N_REQ-1:0] iREQ_DATA;
   logic [N_REQ-1:0]    oGNT;
   logic [N_REQ-1:0]    oDONE;
   logic [1:0]          oERR;
   logic                oBUSY;
   logic [23:0]         oI2C_DATA;
   logic                oI2C_GO;
   logic                iI2C_END;
   logic                iI2C_ACK;

   // Arbiter view
   modport slave (
      input  iREQ, iREQ_DATA, iI2C_END, iI2C_ACK,
      output oGNT, oDONE, oERR, oBUSY, oI2C_DATA, oI2C_GO
   );

   // Requester / controller view
   modport master (
      output iREQ, iREQ_DATA, iI2C_END, iI2C_ACK,
      input  oGNT, oDONE, oERR, oBUSY, oI2C_DATA, oI2C_GO
   );
endinterface

// File: rtl/i2c_ccd_arbiter.sv
// Round-robin arbiter sharing one I2C controller among N_REQ frame sources,
// with NACK retry, watchdog timeout and per-requester completion status.
module i2c_ccd_arbiter #(
   parameter int unsigned N_REQ       = 2,
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned GAP_CYC     = 1000,
   parameter int unsigned TIMEOUT_CYC = 2500000
) (
   input logic              iCLK,
   input logic              iRST,
   i2c_ccd_arbiter_if.slave bus
);
   localparam int unsigned FRAME_W = 24;
   localparam int unsigned PTR_W   = $clog2(N_REQ);
   localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int unsigned WD_W    = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned GAP_W   = $clog2(GAP_CYC + 1);

   localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   typedef enum logic [2:0] {IDLE, WAIT_END, WAIT_REL, GAP, RESP} state_t;

   state_t               state, state_n;
   logic [PTR_W-1:0]     ptr, ptr_n, idx, idx_n, sel;
   logic                 found;
   logic [RETRY_W-1:0]   retry_cnt, retry_n;
   logic [WD_W-1:0]      wdog, wdog_n;
   logic [GAP_W-1:0]     gap_cnt, gap_n;
   logic                 ack_q, ack_n, timed_out, to_n;
   logic [N_REQ-1:0]     gnt, gnt_n, done, done_n;
   logic [1:0]           err, err_n;
   logic                 busy, busy_n, go, go_n;
   logic [FRAME_W-1:0]   i2c_data, data_n;

   // First active request at or above the round-robin pointer, with wrap
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (!found && bus.iREQ[(int'(ptr) + i) % int'(N_REQ)]) begin
            sel   = PTR_W'((int'(ptr) + i) % int'(N_REQ));
            found = 1'b1;
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      idx_n   = idx;
      retry_n = retry_cnt;
      wdog_n  = wdog;
      gap_n   = gap_cnt;
      ack_n   = ack_q;
      to_n    = timed_out;
      gnt_n   = '0;
      done_n  = '0;
      err_n   = err;
      busy_n  = busy;
      data_n  = i2c_data;
      go_n    = go;
      unique case (state)
         IDLE: begin
            if (found) begin
               gnt_n   = N_REQ'(1) << sel;
               data_n  = bus.iREQ_DATA[FRAME_W*sel +: FRAME_W];
               go_n    = 1'b1;
               busy_n  = 1'b1;
               retry_n = '0;
               wdog_n  = '0;
               to_n    = 1'b0;
               idx_n   = sel;
               ptr_n   = (sel == PTR_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
               state_n = WAIT_END;
            end
         end
         WAIT_END: begin
            wdog_n = wdog + 1'b1;
            if (bus.iI2C_END) begin
               ack_n   = bus.iI2C_ACK;
               go_n    = 1'b0;
               state_n = WAIT_REL;
            end else if (wdog == WD_LAST) begin
               go_n    = 1'b0;
               to_n    = 1'b1;
               state_n = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (wdog < WD_LAST) wdog_n = wdog + 1'b1;
            if (!bus.iI2C_END) begin
               if (timed_out) begin
                  done_n  = N_REQ'(1) << idx;
                  err_n   = 2'b10;
                  state_n = RESP;
               end else if (!ack_q) begin
                  done_n  = N_REQ'(1) << idx;
                  err_n   = 2'b00;
                  state_n = RESP;
               end else if (retry_cnt < RETRY_MAX) begin
                  retry_n = retry_cnt + 1'b1;
                  gap_n   = '0;
                  state_n = GAP;
               end else begin
                  done_n  = N_REQ'(1) << idx;
                  err_n   = 2'b01;
                  state_n = RESP;
               end
            end else if (wdog >= WD_LAST) begin
               // controller never released END
               done_n  = N_REQ'(1) << idx;
               err_n   = 2'b10;
               state_n = RESP;
            end
         end
         GAP: begin
            gap_n = gap_cnt + 1'b1;
            if (gap_cnt == GAP_LAST) begin
               go_n    = 1'b1;
               wdog_n  = '0;
               state_n = WAIT_END;
            end
         end
         RESP: begin
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= IDLE;
         ptr       <= '0;
         idx       <= '0;
         retry_cnt <= '0;
         wdog      <= '0;
         gap_cnt   <= '0;
         ack_q     <= 1'b0;
         timed_out <= 1'b0;
         gnt       <= '0;
         done      <= '0;
         err       <= 2'b00;
         busy      <= 1'b0;
         i2c_data  <= '0;
         go        <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         idx       <= idx_n;
         retry_cnt <= retry_n;
         wdog      <= wdog_n;
         gap_cnt   <= gap_n;
         ack_q     <= ack_n;
         timed_out <= to_n;
         gnt       <= gnt_n;
         done      <= done_n;
         err       <= err_n;
         busy      <= busy_n;
         i2c_data  <= data_n;
         go        <= go_n;
      end
   end

   assign bus.oGNT      = gnt;
   assign bus.oDONE     = done;
   assign bus.oERR      = err;
   assign bus.oBUSY     = busy;
   assign bus.oI2C_DATA = i2c_data;
   assign bus.oI2C_GO   = go;
endmodule

// File: tb/tb_i2c_ccd_arbiter.sv
// Self-checking bench for i2c_ccd_arbiter with a behavioural I2C controller.
module tb_i2c_ccd_arbiter;
   localparam int unsigned N_REQ       = 2;
   localparam int unsigned MAX_RETRY   = 3;
   localparam int unsigned GAP_CYC     = 20;
   localparam int unsigned TIMEOUT_CYC = 100;
   localparam int          LAT         = 40;
   localparam int          HOLD        = 3;

   typedef struct {
      logic [N_REQ-1:0] who;
      logic [23:0]      data;
   } gnt_rec_t;

   typedef struct {
      logic [N_REQ-1:0] who;
      logic [1:0]       err;
      int               pulses;
      int               min_low;
      int               last_high;
   } done_rec_t;

   logic iCLK = 1'b0;
   logic iRST;
   int   checks = 0;
   int   errors = 0;

   i2c_ccd_arbiter_if #(.N_REQ(N_REQ)) bus();

   i2c_ccd_arbiter #(
      .N_REQ(N_REQ), .MAX_RETRY(MAX_RETRY), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .iCLK(iCLK),
      .iRST(iRST),
      .bus (bus.slave)
   );

   always #5 iCLK = ~iCLK;

   // Controller model: END rises LAT cycles after GO, held HOLD edges
   bit       hang      = 1'b0;
   logic [7:0] nack_mask = 8'h00;
   int       m_cnt, m_hold, m_att;
   always @(posedge iCLK) begin
      #1;
      if (iRST) begin
         m_cnt = 0; m_hold = 0; m_att = 0;
         bus.iI2C_END = 1'b0;
         bus.iI2C_ACK = 1'b0;
      end else begin
         if (|bus.oGNT) m_att = 0;
         if (bus.iI2C_END) begin
            if (m_hold == 0) bus.iI2C_END = 1'b0;
            else m_hold--;
         end else if (bus.oI2C_GO) begin
            m_cnt++;
            if (!hang && m_cnt == LAT) begin
               bus.iI2C_END = 1'b1;
               bus.iI2C_ACK = nack_mask[m_att];
               m_att++;
               m_hold = HOLD - 1;
               m_cnt  = 0;
            end
         end else begin
            m_cnt = 0;
         end
      end
   end

   // Monitor: records grants and completions with GO pulse statistics
   gnt_rec_t  obs_gnt_q[$], exp_gnt_q[$];
   done_rec_t obs_done_q[$], exp_done_q[$];
   int   p_cnt, low_run, min_low, high_run, last_high;
   logic go_prev;
   always @(negedge iCLK) begin
      gnt_rec_t  g;
      done_rec_t d;
      if (iRST) begin
         p_cnt = 0; low_run = 0; high_run = 0; last_high = 0; go_prev = 1'b0;
         min_low = 1000000;
      end else begin
         if (|bus.oGNT) begin
            g.who  = bus.oGNT;
            g.data = bus.oI2C_DATA;
            obs_gnt_q.push_back(g);
            p_cnt = 0; min_low = 1000000; low_run = 0;
         end
         if (bus.oI2C_GO) begin
            if (!go_prev) begin
               p_cnt++;
               if (p_cnt > 1 && low_run < min_low) min_low = low_run;
               high_run = 0;
            end
            high_run++;
            last_high = high_run;
            low_run   = 0;
         end else begin
            low_run++;
         end
         if (|bus.oDONE) begin
            d.who = bus.oDONE; d.err = bus.oERR; d.pulses = p_cnt;
            d.min_low = min_low; d.last_high = last_high;
            obs_done_q.push_back(d);
         end
         go_prev = bus.oI2C_GO;
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge iCLK);
         #1;
      end
   endtask

   task automatic wait_done(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         cycles(1);
         if (obs_done_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic clear_queues();
      obs_gnt_q.delete(); obs_done_q.delete();
      exp_gnt_q.delete(); exp_done_q.delete();
   endtask

   task automatic test_reset();
      bus.iREQ = '0; bus.iREQ_DATA = '0;
      iRST = 1'b1;
      cycles(2);
      checks++; if (bus.oGNT !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", bus.oGNT); end
      checks++; if (bus.oDONE !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", bus.oDONE); end
      checks++; if (bus.oERR !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", bus.oERR); end
      checks++; if (bus.oBUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.oBUSY); end
      checks++; if (bus.oI2C_GO !== 1'b0) begin errors++; $display("FAIL reset_go got %b want 0", bus.oI2C_GO); end
      checks++; if (bus.oI2C_DATA !== 24'h0) begin errors++; $display("FAIL reset_data got %h want 000000", bus.oI2C_DATA); end
      iRST = 1'b0;
      cycles(1);
   endtask

   task automatic test_single();
      bit ok;
      gnt_rec_t g, eg;
      done_rec_t d, ed;
      clear_queues();
      nack_mask = 8'h00; hang = 1'b0;
      eg.who = 2'b01; eg.data = 24'hBA2000; exp_gnt_q.push_back(eg);
      ed.who = 2'b01; ed.err = 2'b00; ed.pulses = 1; ed.min_low = 0; ed.last_high = LAT;
      exp_done_q.push_back(ed);
      bus.iREQ_DATA[23:0] = 24'hBA2000;
      bus.iREQ = 2'b01;
      cycles(1);
      checks++; if (bus.oGNT !== 2'b01 || bus.oI2C_GO !== 1'b1 || bus.oBUSY !== 1'b1)
         begin errors++; $display("FAIL single_grant gnt=%b go=%b busy=%b want 01/1/1", bus.oGNT, bus.oI2C_GO, bus.oBUSY); end
      bus.iREQ = 2'b00;
      wait_done(1, 300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout no oDONE within budget"); end
      checks++; if (bus.oBUSY !== 1'b1) begin errors++; $display("FAIL single_busy_done got %b want 1", bus.oBUSY); end
      cycles(1);
      checks++; if (bus.oBUSY !== 1'b0 || bus.oDONE !== 2'b00)
         begin errors++; $display("FAIL single_after busy=%b done=%b want 0/00", bus.oBUSY, bus.oDONE); end
      g = (obs_gnt_q.size() > 0) ? obs_gnt_q.pop_front() : '{who: '0, data: '0};
      eg = exp_gnt_q.pop_front();
      checks++; if (g.who !== eg.who || g.data !== eg.data)
         begin errors++; $display("FAIL single_gnt_rec got %b/%h want %b/%h", g.who, g.data, eg.who, eg.data); end
      d = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : '{who: '0, err: '1, pulses: 0, min_low: 0, last_high: 0};
      ed = exp_done_q.pop_front();
      checks++; if (d.who !== ed.who || d.err !== ed.err || d.pulses != ed.pulses || d.last_high != ed.last_high)
         begin errors++; $display("FAIL single_done got %b/%b/%0d/%0d want %b/%b/%0d/%0d",
            d.who, d.err, d.pulses, d.last_high, ed.who, ed.err, ed.pulses, ed.last_high); end
   endtask

   task automatic test_contention();
      bit ok;
      int g0;
      gnt_rec_t g, eg;
      done_rec_t d, ed;
      iRST = 1'b1; cycles(1); iRST = 1'b0;
      clear_queues();
      eg.who = 2'b01; eg.data = 24'hBA0907; exp_gnt_q.push_back(eg);
      eg.who = 2'b10; eg.data = 24'hBAF101; exp_gnt_q.push_back(eg);
      eg.who = 2'b01; eg.data = 24'hBA2B00; exp_gnt_q.push_back(eg);
      ed.err = 2'b00; ed.pulses = 1; ed.min_low = 0; ed.last_high = LAT;
      ed.who = 2'b01; exp_done_q.push_back(ed);
      ed.who = 2'b10; exp_done_q.push_back(ed);
      ed.who = 2'b01; exp_done_q.push_back(ed);
      bus.iREQ_DATA = {24'hBAF101, 24'hBA0907};
      bus.iREQ = 2'b11;
      g0 = 0; ok = 1'b0;
      for (int c = 0; c < 600; c++) begin
         cycles(1);
         if (bus.oGNT[0]) begin
            g0++;
            if (g0 == 1) bus.iREQ_DATA[23:0] = 24'hBA2B00;
            else bus.iREQ[0] = 1'b0;
         end
         if (bus.oGNT[1]) bus.iREQ[1] = 1'b0;
         if (obs_done_q.size() >= 3) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL contention_timeout dones=%0d want 3", obs_done_q.size()); end
      checks++; if (obs_gnt_q.size() != 3) begin errors++; $display("FAIL contention_gnt_count got %0d want 3", obs_gnt_q.size()); end
      while (exp_gnt_q.size() > 0) begin
         eg = exp_gnt_q.pop_front();
         g = (obs_gnt_q.size() > 0) ? obs_gnt_q.pop_front() : '{who: '0, data: '0};
         checks++; if (g.who !== eg.who || g.data !== eg.data)
            begin errors++; $display("FAIL contention_gnt got %b/%h want %b/%h", g.who, g.data, eg.who, eg.data); end
      end
      while (exp_done_q.size() > 0) begin
         ed = exp_done_q.pop_front();
         d = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : '{who: '0, err: '1, pulses: 0, min_low: 0, last_high: 0};
         checks++; if (d.who !== ed.who || d.err !== ed.err || d.pulses != ed.pulses)
            begin errors++; $display("FAIL contention_done got %b/%b/%0d want %b/%b/%0d",
               d.who, d.err, d.pulses, ed.who, ed.err, ed.pulses); end
      end
      cycles(2);
   endtask

   task automatic test_nack(input logic [7:0] mask, input logic [1:0] who,
                            input logic [23:0] frame, input int pulses, input logic [1:0] err);
      bit ok;
      done_rec_t d, ed;
      gnt_rec_t g;
      clear_queues();
      nack_mask = mask; hang = 1'b0;
      ed.who = who; ed.err = err; ed.pulses = pulses; ed.min_low = int'(GAP_CYC); ed.last_high = LAT;
      exp_done_q.push_back(ed);
      if (who[0]) bus.iREQ_DATA[23:0] = frame; else bus.iREQ_DATA[47:24] = frame;
      bus.iREQ = who;
      cycles(1);
      bus.iREQ = 2'b00;
      wait_done(1, 1000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL nack_timeout mask=%h no oDONE", mask); end
      g = (obs_gnt_q.size() > 0) ? obs_gnt_q.pop_front() : '{who: '0, data: '0};
      checks++; if (g.who !== who || g.data !== frame)
         begin errors++; $display("FAIL nack_gnt got %b/%h want %b/%h", g.who, g.data, who, frame); end
      d = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : '{who: '0, err: '1, pulses: 0, min_low: 0, last_high: 0};
      ed = exp_done_q.pop_front();
      checks++; if (d.who !== ed.who || d.err !== ed.err || d.pulses != ed.pulses)
         begin errors++; $display("FAIL nack_done got %b/%b/%0d pulses want %b/%b/%0d",
            d.who, d.err, d.pulses, ed.who, ed.err, ed.pulses); end
      checks++; if (d.min_low < ed.min_low)
         begin errors++; $display("FAIL nack_gap got %0d low cycles want >= %0d", d.min_low, ed.min_low); end
      cycles(3);
      checks++; if (obs_done_q.size() != 0 || bus.oBUSY !== 1'b0)
         begin errors++; $display("FAIL nack_extra dones=%0d busy=%b want 0/0", obs_done_q.size(), bus.oBUSY); end
   endtask

   task automatic test_timeout();
      bit ok;
      int go_seen;
      done_rec_t d, ed;
      clear_queues();
      hang = 1'b1; nack_mask = 8'h00;
      ed.who = 2'b10; ed.err = 2'b10; ed.pulses = 1; ed.min_low = 0; ed.last_high = int'(TIMEOUT_CYC);
      exp_done_q.push_back(ed);
      bus.iREQ_DATA[47:24] = 24'hABCDEF;
      bus.iREQ = 2'b10;
      cycles(1);
      bus.iREQ = 2'b00;
      wait_done(1, 400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL timeout_wait no oDONE"); end
      d = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : '{who: '0, err: '0, pulses: 0, min_low: 0, last_high: 0};
      ed = exp_done_q.pop_front();
      checks++; if (d.who !== ed.who || d.err !== ed.err || d.pulses != ed.pulses || d.last_high != ed.last_high)
         begin errors++; $display("FAIL timeout_done got %b/%b/%0d/%0d want %b/%b/%0d/%0d",
            d.who, d.err, d.pulses, d.last_high, ed.who, ed.err, ed.pulses, ed.last_high); end
      go_seen = 0;
      for (int c = 0; c < 50; c++) begin
         cycles(1);
         if (bus.oI2C_GO) go_seen++;
      end
      checks++; if (go_seen != 0) begin errors++; $display("FAIL timeout_retry got %0d GO cycles want 0", go_seen); end
      hang = 1'b0;
      obs_gnt_q.delete();
      bus.iREQ_DATA[23:0] = 24'hBA2000;
      bus.iREQ = 2'b01;
      cycles(1);
      bus.iREQ = 2'b00;
      wait_done(1, 300, ok);
      d = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : '{who: '0, err: '1, pulses: 0, min_low: 0, last_high: 0};
      checks++; if (!ok || d.who !== 2'b01 || d.err !== 2'b00 || d.pulses != 1)
         begin errors++; $display("FAIL timeout_next got %b/%b/%0d want 01/00/1", d.who, d.err, d.pulses); end
      cycles(2);
   endtask

   task automatic test_reset_mid();
      bit ok;
      done_rec_t d;
      clear_queues();
      bus.iREQ_DATA[23:0] = 24'h111111;
      bus.iREQ = 2'b01;
      cycles(1);
      bus.iREQ = 2'b00;
      cycles(10);
      iRST = 1'b1;
      cycles(1);
      checks++; if (bus.oI2C_GO !== 1'b0 || bus.oBUSY !== 1'b0)
         begin errors++; $display("FAIL rstmid_outputs go=%b busy=%b want 0/0", bus.oI2C_GO, bus.oBUSY); end
      iRST = 1'b0;
      cycles(60);
      checks++; if (obs_done_q.size() != 0) begin errors++; $display("FAIL rstmid_done got %0d dones want 0", obs_done_q.size()); end
      obs_gnt_q.delete();
      bus.iREQ_DATA = {24'h333333, 24'h222222};
      bus.iREQ = 2'b11;
      cycles(1);
      checks++; if (bus.oGNT !== 2'b01 || bus.oI2C_DATA !== 24'h222222)
         begin errors++; $display("FAIL rstmid_grant got %b/%h want 01/222222", bus.oGNT, bus.oI2C_DATA); end
      bus.iREQ[0] = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         cycles(1);
         if (bus.oGNT[1]) bus.iREQ[1] = 1'b0;
         if (obs_done_q.size() >= 2) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_wait dones=%0d want 2", obs_done_q.size()); end
      d = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : '{who: '0, err: '1, pulses: 0, min_low: 0, last_high: 0};
      checks++; if (d.who !== 2'b01 || d.err !== 2'b00)
         begin errors++; $display("FAIL rstmid_done0 got %b/%b want 01/00", d.who, d.err); end
      d = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : '{who: '0, err: '1, pulses: 0, min_low: 0, last_high: 0};
      checks++; if (d.who !== 2'b10 || d.err !== 2'b00)
         begin errors++; $display("FAIL rstmid_done1 got %b/%b want 10/00", d.who, d.err); end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_nack(8'h03, 2'b10, 24'h5A1234, 3, 2'b00);
      test_nack(8'hFF, 2'b01, 24'h123456, 4, 2'b01);
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_ccd_arbiter.md
Name: i2c_ccd_arbiter

Overview:
- Shares the single I2C_Controller instance (24-bit {slave addr, sub addr, data} frames) among N_REQ requesters: the boot configuration sequencer, the runtime exposure/gain updater and the debug path.
- Round-robin grant, latched frame, GO/END handshake toward the controller, bounded retry on NACK, watchdog timeout, per-requester completion status.
- Runs on iCLK. The controller's END/ACK are already synchronised into iCLK upstream.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- MAX_RETRY, 3, re-attempts after a NACK before reporting failure (0 = no retry).
- GAP_CYC, 1000, iCLK cycles idle between a NACK and the retry launch (>=1).
- TIMEOUT_CYC, 2500000, max iCLK cycles in WAIT_END before abort (50 ms at 50 MHz).

Ports:
- iCLK  in  1  system clock
- iRST  in  1  synchronous reset, active-high
- iREQ  in  N_REQ  per-requester request level
- iREQ_DATA  in  24*N_REQ  frame of requester k at bits [24k+23:24k]
- oGNT  out  N_REQ  one-hot, 1-cycle pulse: frame accepted
- oDONE  out  N_REQ  one-hot, 1-cycle pulse: transaction finished
- oERR  out  2  status, valid with oDONE: 00 ok, 01 NACK exhausted, 10 timeout
- oBUSY  out  1  high from grant through oDONE cycle inclusive
- oI2C_DATA  out  24  frame to controller
- oI2C_GO  out  1  start to controller
- iI2C_END  in  1  controller transfer complete (level)
- iI2C_ACK  in  1  1 = NACK seen during transfer

Behaviour:
- Reset (all registered, next edge with iRST=1): oGNT=0, oDONE=0, oERR=00, oBUSY=0, oI2C_GO=0, oI2C_DATA=0, RR pointer=0, retry cnt=0, state IDLE. A reset mid-transfer drops GO on that edge. No oDONE is issued for the aborted frame.
- Requester contract: hold iREQ=1 with a stable frame until oGNT. After the grant it may deassert, or keep iREQ high to queue the next frame, but only with the new frame already on iREQ_DATA.
- States: IDLE, WAIT_END, WAIT_REL, GAP, RESP.
- IDLE:
  - If any iREQ=1, select the first set bit searching upward from the RR pointer, with wrap.
  - Next edge: latch that frame into oI2C_DATA, set oGNT[k]=1 (one cycle), oI2C_GO=1, oBUSY=1, clear retry cnt and watchdog, set pointer=(k+1) mod N_REQ, go to WAIT_END.
  - GO therefore rises exactly 1 cycle after iREQ is sampled.
- WAIT_END:
  - The watchdog increments each cycle.
  - On iI2C_END=1: latch iI2C_ACK, GO=0 next edge, go to WAIT_REL.
  - If the watchdog reaches TIMEOUT_CYC-1 with END still low: GO=0, result=10, go to WAIT_REL. No retry follows a timeout.
  - If END and the timeout occur in the same cycle, END wins (ACK is evaluated).
- WAIT_REL:
  - Wait for iI2C_END=0 (controller re-armed). This wait is also bounded by the watchdog; overflow gives result 10.
  - Then:
    - ACK=0: result 00, go to RESP.
    - NACK with retry cnt<MAX_RETRY: cnt+1, go to GAP.
    - NACK with retry cnt=MAX_RETRY: result 01, go to RESP.
- GAP:
  - Count GAP_CYC cycles with GO=0.
  - Then re-assert GO with the same latched frame, reset the watchdog, go to WAIT_END.
  - No re-arbitration happens during retries.
- RESP: oDONE[k]=1 and oERR=result for one cycle, then IDLE with oBUSY=0.
  - A new grant can occur at the earliest 1 cycle after RESP, so back-to-back frames are spaced by at least 2 cycles between oDONE and the next GO.
- oERR is held after RESP until the next RESP; it is valid only when qualified by oDONE.
- Requests arriving while busy are not lost, because the iREQ levels are re-sampled in IDLE.
- Fairness: with all requesters permanently requesting, grants rotate 0,1,..,N_REQ-1,0.
- Widths: the watchdog is sized $clog2(TIMEOUT_CYC+1) and the gap counter $clog2(GAP_CYC+1). The retry counter is sized for MAX_RETRY.
- A frame is the full 24-bit value. The arbiter does not interpret its contents.

Test Plan:
- Single request: iREQ=01, frame 0xBA2000; controller model asserts END 40 cycles after GO, ACK=0 -> oGNT=01 one cycle after req, oI2C_DATA=0xBA2000, GO high 40 cycles, oDONE=01 with oERR=00, oBUSY back low.
- Contention: iREQ=11 from reset, frames 0xBA0907 / 0xBAF101 -> grants in order 01,10,01 (requester 0 re-requests with 0xBA2B00); each frame appears on oI2C_DATA exactly once per grant.
- NACK retry then success: ACK=1 on attempts 1–2, ACK=0 on attempt 3 -> 3 GO pulses separated by ≥GAP_CYC low cycles, one oDONE, oERR=00.
- NACK exhausted: ACK=1 always, MAX_RETRY=3 -> exactly 4 GO pulses, oDONE with oERR=01.
- Timeout: END never asserts, TIMEOUT_CYC=100 -> GO drops after 100 cycles, oDONE with oERR=10, no retry, next request served normally.
- Reset mid-transfer: assert iRST for 1 cycle while in WAIT_END -> GO=0, oBUSY=0 next edge, no oDONE; pointer=0, so requester 0 wins the next contention.
